// File: rtl/seg7_scan_driver_pkg.sv
// seg7_pkg: shared constants and the hex-to-segment encoder for the
// multiplexed 7-segment scan driver.
//   SEG_BLANK   : all segments off ({dp,g,f,e,d,c,b,a}, active-low)
//   SEG_TABLE   : 16-entry hex-to-segment table, dp bit held at 1 (off)
//   seg7_encode : nibble + dp request -> 8-bit active-low segment code
package seg7_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [7:0] SEG_TABLE [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  function automatic logic [7:0] seg7_encode(input logic [3:0] nibble, input logic dp);
    logic [7:0] code;
    code    = SEG_TABLE[nibble];
    code[7] = ~dp;
    return code;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if: display-data load bus between the BCD datapath
// (master) and the scan driver (slave).
//   bcd_in   : 4*N_DIGITS digit values, digit k at [4k+3:4k]
//   dp_in    : decimal point request per digit, 1 = lit
//   digit_en : per-digit enable, 0 = digit dark
//   load     : one-cycle strobe capturing the three fields above
interface seg7_scan_driver_if #(
  parameter int unsigned N_DIGITS = 8
);

  logic [4*N_DIGITS-1:0] bcd_in;
  logic [N_DIGITS-1:0]   dp_in;
  logic [N_DIGITS-1:0]   digit_en;
  logic                  load;

  modport master (output bcd_in, dp_in, digit_en, load);
  modport slave  (input  bcd_in, dp_in, digit_en, load);

endinterface

// File: rtl/seg7_scan_driver_lzb_mask.sv
// seg7_lzb_mask: combinational leading-zero blanking mask.
//   bcd_i   : digit values, one nibble per digit
//   dp_i    : decimal point per digit
//   en_i    : digit enable per digit
//   blank_o : 1 = digit is a leading zero and must be dark
// An enabled zero digit k > 0 is blanked while every enabled digit above it
// is zero with its decimal point off. Disabled digits do not break the run.
// Digit 0 is never blanked.
module seg7_lzb_mask #(
  parameter int unsigned N_DIGITS = 8
) (
  input  logic [N_DIGITS-1:0][3:0] bcd_i,
  input  logic [N_DIGITS-1:0]      dp_i,
  input  logic [N_DIGITS-1:0]      en_i,
  output logic [N_DIGITS-1:0]      blank_o
);

  logic lead;

  always_comb begin
    blank_o = '0;
    lead    = 1'b1;
    for (int unsigned k = N_DIGITS - 1; k >= 1; k--) begin
      if (en_i[k]) begin
        if (lead && (bcd_i[k] == 4'd0)) begin
          blank_o[k] = 1'b1;
        end
        lead = lead & (bcd_i[k] == 4'd0) & ~dp_i[k];
      end
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: parametrised multiplexed 7-segment display driver.
//   clk_scan        : system clock, rising edge
//   scancnt_reset   : synchronous active-high reset
//   load_bus        : display data load bus (slave modport)
//   display_dig_sel : digit select, active-low
//   seg7cod_out     : {dp,g,f,e,d,c,b,a}, active-low
//   scan_wrap       : one-cycle pulse after the last digit slot ends
// Optional build macro SEG7_LZB_EN enables leading-zero blanking.
// Loads are staged and promoted to the active buffer only at the frame
// boundary, so a frame never mixes old and new data. Each slot starts with
// one dark cycle to suppress ghosting; all outputs are registered.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned N_DIGITS = 8,
  parameter int unsigned DIV      = 50000
) (
  input  logic                clk_scan,
  input  logic                scancnt_reset,
  seg7_scan_driver_if.slave   load_bus,
  output logic [N_DIGITS-1:0] display_dig_sel,
  output logic [7:0]          seg7cod_out,
  output logic                scan_wrap
);

  localparam int unsigned SEL_W = $clog2(N_DIGITS);
  localparam int unsigned CNT_W = $clog2(DIV);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_DIGITS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [SEL_W-1:0] idx_q;
  logic             tick;
  logic             boundary;

  logic                      pend_q, pend_d;
  logic [N_DIGITS-1:0][3:0]  stg_bcd_q;
  logic [N_DIGITS-1:0]       stg_dp_q, stg_en_q;
  logic [N_DIGITS-1:0][3:0]  act_bcd_q, act_bcd_d;
  logic [N_DIGITS-1:0]       act_dp_q, act_dp_d;
  logic [N_DIGITS-1:0]       act_en_q, act_en_d;
  logic [N_DIGITS-1:0]       blank_mask;

  logic [N_DIGITS-1:0] sel_q, sel_d;
  logic [7:0]          seg_q, seg_d;
  logic                wrap_q;

  assign tick     = (cnt_q == LAST_CNT);
  assign boundary = tick && (idx_q == LAST_IDX);

  // Active buffer update: a load coinciding with the boundary bypasses the
  // staging registers; otherwise a pending staged load is promoted.
  always_comb begin
    act_bcd_d = act_bcd_q;
    act_dp_d  = act_dp_q;
    act_en_d  = act_en_q;
    pend_d    = pend_q;
    if (load_bus.load) begin
      if (boundary) begin
        act_bcd_d = load_bus.bcd_in;
        act_dp_d  = load_bus.dp_in;
        act_en_d  = load_bus.digit_en;
        pend_d    = 1'b0;
      end else begin
        pend_d = 1'b1;
      end
    end else if (boundary && pend_q) begin
      act_bcd_d = stg_bcd_q;
      act_dp_d  = stg_dp_q;
      act_en_d  = stg_en_q;
      pend_d    = 1'b0;
    end
  end

`ifdef SEG7_LZB_EN
  logic [N_DIGITS-1:0] blank_d, blank_q;

  // Mask is derived from the next active contents so it updates together
  // with the active buffer.
  seg7_lzb_mask #(
    .N_DIGITS (N_DIGITS)
  ) u_lzb (
    .bcd_i   (act_bcd_d),
    .dp_i    (act_dp_d),
    .en_i    (act_en_d),
    .blank_o (blank_d)
  );

  always_ff @(posedge clk_scan) begin
    if (scancnt_reset) begin
      blank_q <= '0;
    end else begin
      blank_q <= blank_d;
    end
  end

  assign blank_mask = blank_q;
`else
  assign blank_mask = '0;
`endif

  // The tick cycle still holds the old index, so the registered output
  // computed there becomes the dead cycle; the new digit follows one later.
  always_comb begin
    sel_d = '1;
    seg_d = SEG_BLANK;
    if (!tick && act_en_q[idx_q] && !blank_mask[idx_q]) begin
      sel_d[idx_q] = 1'b0;
      seg_d        = seg7_encode(act_bcd_q[idx_q], act_dp_q[idx_q]);
    end
  end

  always_ff @(posedge clk_scan) begin
    if (scancnt_reset) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      pend_q    <= 1'b0;
      stg_bcd_q <= '0;
      stg_dp_q  <= '0;
      stg_en_q  <= '0;
      act_bcd_q <= '0;
      act_dp_q  <= '0;
      act_en_q  <= '0;
      sel_q     <= '1;
      seg_q     <= SEG_BLANK;
      wrap_q    <= 1'b0;
    end else begin
      cnt_q <= tick ? '0 : cnt_q + 1'b1;
      if (tick) begin
        idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
      end
      if (load_bus.load) begin
        stg_bcd_q <= load_bus.bcd_in;
        stg_dp_q  <= load_bus.dp_in;
        stg_en_q  <= load_bus.digit_en;
      end
      pend_q    <= pend_d;
      act_bcd_q <= act_bcd_d;
      act_dp_q  <= act_dp_d;
      act_en_q  <= act_en_d;
      sel_q     <= sel_d;
      seg_q     <= seg_d;
      wrap_q    <= boundary;
    end
  end

  assign display_dig_sel = sel_q;
  assign seg7cod_out     = seg_q;
  assign scan_wrap       = wrap_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed self-checking bench for seg7_scan_driver
// with N_DIGITS=8, DIV=4 (32-cycle frame). Expected outputs are hand
// computed constants. Compile with SEG7_LZB_EN to check blanking.
module tb_seg7_scan_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] dig_sel;
  logic [7:0] seg;
  logic       wrap;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  logic [31:0] ld_bcd;
  logic [7:0]  ld_dp;
  logic [7:0]  ld_en;

  always #5 clk = ~clk;

  seg7_scan_driver_if #(.N_DIGITS(8)) bus ();

  seg7_scan_driver #(
    .N_DIGITS (8),
    .DIV      (4)
  ) dut (
    .clk_scan        (clk),
    .scancnt_reset   (rst),
    .load_bus        (bus),
    .display_dig_sel (dig_sel),
    .seg7cod_out     (seg),
    .scan_wrap       (wrap)
  );

  localparam logic [7:0][7:0] EXP_T1  = {8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0};
  localparam logic [7:0][7:0] EXP_1S  = {8{8'hF9}};
  localparam logic [7:0][7:0] EXP_8S  = {8{8'h80}};
  localparam logic [7:0][7:0] EXP_BYP = {8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h92};
  localparam logic [7:0][7:0] EXP_T4  = {8'hF8, 8'h82, 8'h92, 8'h99, 8'hFF, 8'h08, 8'hF9, 8'hC0};
`ifdef SEG7_LZB_EN
  localparam logic [7:0][7:0] EXP_T6  = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h99, 8'hF8, 8'hC0};
  localparam logic [7:0]      EN_T6   = 8'h07;
`else
  localparam logic [7:0][7:0] EXP_T6  = {8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'h99, 8'hF8, 8'hC0};
  localparam logic [7:0]      EN_T6   = 8'hFF;
`endif

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_load(input logic [31:0] b, input logic [7:0] d, input logic [7:0] e);
    ld_bcd = b;
    ld_dp  = d;
    ld_en  = e;
  endtask

  task automatic drive_load();
    bus.bcd_in   = ld_bcd;
    bus.dp_in    = ld_dp;
    bus.digit_en = ld_en;
    bus.load     = 1'b1;
  endtask

  task automatic wait_wrap();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 64; i++) begin
      step(1);
      if (wrap) begin
        found = 1'b1;
        break;
      end
    end
    chk("wrap_seen", 32'(found), 32'd1);
  endtask

  // Entered on the dead cycle of digit 0 (scan_wrap high); leaves on the
  // dead cycle of digit 0 of the following frame. ld_k pulses load in the
  // dead cycle of slot ld_k; ld_tick pulses it in the frame boundary tick.
  task automatic check_frame(input string tag, input logic [7:0][7:0] exp,
                             input logic [7:0] en, input int ld_k, input bit ld_tick);
    logic [7:0] exp_sel;
    logic [7:0] exp_seg;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("%s_dead%0d_sel", tag, k), 32'(dig_sel), 32'hFF);
      chk($sformatf("%s_dead%0d_seg", tag, k), 32'(seg), 32'hFF);
      chk($sformatf("%s_dead%0d_wrap", tag, k), 32'(wrap), (k == 0) ? 32'd1 : 32'd0);
      if (k == ld_k) begin
        drive_load();
        step(1);
        bus.load = 1'b0;
        step(1);
      end else begin
        step(2);
      end
      exp_sel = en[k] ? ~(8'd1 << k) : 8'hFF;
      exp_seg = en[k] ? exp[k] : 8'hFF;
      chk($sformatf("%s_dig%0d_sel", tag, k), 32'(dig_sel), 32'(exp_sel));
      chk($sformatf("%s_dig%0d_seg", tag, k), 32'(seg), 32'(exp_seg));
      chk($sformatf("%s_dig%0d_wrap", tag, k), 32'(wrap), 32'd0);
      if (k == 7 && ld_tick) begin
        step(1);
        drive_load();
        step(1);
        bus.load = 1'b0;
      end else begin
        step(2);
      end
    end
  endtask

  initial begin
    bus.bcd_in   = '0;
    bus.dp_in    = '0;
    bus.digit_en = '0;
    bus.load     = 1'b0;
    rst          = 1'b1;
    step(3);
    chk("rst_sel", 32'(dig_sel), 32'hFF);
    chk("rst_seg", 32'(seg), 32'hFF);
    chk("rst_wrap", 32'(wrap), 32'd0);
    chk("rst_pend", 32'(dut.pend_q), 32'd0);
    rst = 1'b0;

    // Basic scan of 0..7
    set_load(32'h76543210, 8'h00, 8'hFF);
    drive_load();
    step(1);
    bus.load = 1'b0;
    wait_wrap();

    // Mid-frame loads take effect only in the next frame
    set_load(32'h11111111, 8'h00, 8'hFF);
    check_frame("t1", EXP_T1, 8'hFF, 3, 1'b0);
    set_load(32'h88888888, 8'h00, 8'hFF);
    check_frame("t2a", EXP_1S, 8'hFF, 4, 1'b0);

    // Load in the boundary tick bypasses staging
    set_load(32'h88888885, 8'h00, 8'hFF);
    check_frame("t2b", EXP_8S, 8'hFF, -1, 1'b1);
    chk("t3_pend", 32'(dut.pend_q), 32'd0);

    // Disabled digit and decimal point
    set_load(32'h76543A10, 8'h04, 8'hF7);
    check_frame("t3", EXP_BYP, 8'hFF, 1, 1'b0);
    set_load(32'h00000470, 8'h00, 8'hFF);
    check_frame("t4", EXP_T4, 8'hF7, 0, 1'b0);

    // Leading zeros
    check_frame("t6", EXP_T6, EN_T6, -1, 1'b0);

    // Reset mid-slot, then dark until load and boundary
    step(2);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("t5_rst_sel", 32'(dig_sel), 32'hFF);
    chk("t5_rst_seg", 32'(seg), 32'hFF);
    chk("t5_rst_wrap", 32'(wrap), 32'd0);
    set_load(32'h76543210, 8'h00, 8'hFF);
    step(1);
    drive_load();
    step(1);
    bus.load = 1'b0;
    chk("t5_dark_sel", 32'(dig_sel), 32'hFF);
    chk("t5_dark_seg", 32'(seg), 32'hFF);
    step(29);
    chk("t5_tick_sel", 32'(dig_sel), 32'hFF);
    chk("t5_tick_seg", 32'(seg), 32'hFF);
    chk("t5_tick_wrap", 32'(wrap), 32'd0);
    step(1);
    check_frame("t5", EXP_T1, 8'hFF, -1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
